// File: rtl/bcd_code_tx_if.sv
// rtl/bcd_code_tx_if.sv - request/serial-status bundle for the BCD code transmitter
interface bcd_code_tx_if;
  logic       start;
  logic [7:0] code;
  logic       tx;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output start, code, input tx, busy, done, err);
  modport slave  (input start, code, output tx, busy, done, err);
endinterface

// File: rtl/bcd_code_tx.sv
// rtl/bcd_code_tx.sv - serialises a two-digit BCD code as start, 8 data LSB-first, parity, stop
module bcd_code_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EVEN  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  bcd_code_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] shreg, shreg_nx;
  logic       par, par_nx;
  logic       tx_q, busy_q, done_q, err_q;
  logic       tx_nx, busy_nx, done_nx, err_nx;
  logic       bit_end;
  logic       code_ok;

  assign bit_end = (cnt == LAST_CNT);
  assign code_ok = (bus.code[7:4] <= 4'd9) && (bus.code[3:0] <= 4'd9);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_nx     = par;
    tx_nx      = tx_q;
    busy_nx    = busy_q;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        tx_nx      = 1'b1;
        busy_nx    = 1'b0;
        cnt_nx     = 8'd0;
        bit_idx_nx = 3'd0;
        if (bus.start) begin
          if (code_ok) begin
            shreg_nx = bus.code;
            par_nx   = (^bus.code) ^ ~PARITY_EVEN;
            state_nx = START;
            tx_nx    = 1'b0;
            busy_nx  = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = 8'd0;
          state_nx = DATA;
          tx_nx    = shreg[0];
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          // shreg[0] is always the bit currently on the line
          cnt_nx   = 8'd0;
          shreg_nx = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nx = PARITY;
            tx_nx    = par;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = shreg[1];
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_nx   = 8'd0;
          state_nx = STOP;
          tx_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
          tx_nx    = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
      tx_q    <= tx_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_code_tx.sv
// tb/tb_bcd_code_tx.sv - bench for bcd_code_tx: vector table, frame scoreboard, corner sequences
module tb_bcd_code_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  bcd_code_tx_if b0();
  bcd_code_tx_if b1();

  bcd_code_tx #(.CLKS_PER_BIT(4), .PARITY_EVEN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b0));
  bcd_code_tx #(.CLKS_PER_BIT(1), .PARITY_EVEN(1'b0)) dut_odd (
    .clk(clk), .reset_n(reset_n), .bus(b1));

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct {logic [7:0] code; logic par;} exp_t;
  typedef struct {logic [7:0] code; logic bad; logic par;} vec_t;
  exp_t sbq[$];
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // frame monitor for the 4-cycle/even instance
  int bcount = 0;
  logic [43:0] samp;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    logic [10:0] f;
    logic [43:0] expv;
    if (!reset_n) begin
      bcount = 0;
      prev_done = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (b0.busy) begin
        if (bcount < 44) samp[bcount] = b0.tx;
        bcount++;
      end
      if (b0.done || b0.err) begin
        chk("done_err_exclusive", b0.done & b0.err, 0);
        chk("pulse_one_cycle", (b0.done & prev_done) | (b0.err & prev_err), 0);
      end
      if (b0.err) err_cnt++;
      if (b0.done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          f = {1'b1, e.par, e.code, 1'b0};
          for (int k = 0; k < 44; k++) expv[k] = f[k/4];
          chk("busy_len", bcount, 44);
          chk("frame_bits", samp, expv);
        end
        bcount = 0;
      end
      prev_done = b0.done;
      prev_err = b0.err;
    end
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (!b0.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, b0.done, 1);
  endtask

  initial begin
    int d0, e0, dd;
    logic [10:0] got, gbusy;
    reset_n = 1'b0;
    b0.start = 1'b0; b0.code = 8'h00;
    b1.start = 1'b0; b1.code = 8'h00;
    vt[0] = '{8'h43, 1'b0, 1'b1};
    vt[1] = '{8'h99, 1'b0, 1'b0};
    vt[2] = '{8'h00, 1'b0, 1'b0};
    vt[3] = '{8'h01, 1'b0, 1'b1};
    vt[4] = '{8'h57, 1'b0, 1'b1};
    vt[5] = '{8'h80, 1'b0, 1'b1};
    vt[6] = '{8'h4A, 1'b1, 1'b0};
    vt[7] = '{8'hA0, 1'b1, 1'b0};
    vt[8] = '{8'h9F, 1'b1, 1'b0};
    vt[9] = '{8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_tx", b0.tx, 1);
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_err", b0.err, 0);
    chk("rst_tx_odd", b1.tx, 1);

    // request on the very first edge out of reset
    reset_n = 1'b1; b0.start = 1'b1; b0.code = 8'h43;
    sbq.push_back('{8'h43, 1'b1});
    @(negedge clk);
    b0.start = 1'b0;
    chk("first_accept_busy", b0.busy, 1);
    chk("first_accept_tx", b0.tx, 0);
    wait_done("first_done");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b0.start = 1'b1; b0.code = vt[i].code;
      if (!vt[i].bad) sbq.push_back('{vt[i].code, vt[i].par});
      @(negedge clk);
      b0.start = 1'b0; b0.code = 8'($urandom);
      if (vt[i].bad) begin
        chk("rej_err", b0.err, 1);
        chk("rej_busy", b0.busy, 0);
        chk("rej_tx", b0.tx, 1);
        @(negedge clk);
        chk("rej_err_clear", b0.err, 0);
        chk("rej_busy_after", b0.busy, 0);
        chk("rej_tx_after", b0.tx, 1);
        chk("rej_no_done", b0.done, 0);
      end else begin
        chk("vec_busy", b0.busy, 1);
        chk("vec_start_bit", b0.tx, 0);
        wait_done("vec_done");
      end
    end

    // start and code changes during a frame are ignored
    @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    b0.start = 1'b1; b0.code = 8'h43;
    sbq.push_back('{8'h43, 1'b1});
    @(negedge clk);
    b0.start = 1'b0;
    repeat (9) @(negedge clk);
    b0.start = 1'b1; b0.code = 8'h12;
    @(negedge clk);
    b0.start = 1'b0; b0.code = 8'($urandom);
    wait_done("busy_ign_done");
    repeat (5) @(negedge clk);
    chk("busy_ign_single_done", done_cnt - d0, 1);
    chk("busy_ign_no_err", err_cnt - e0, 0);
    chk("busy_ign_idle", b0.busy, 0);

    // reset mid-frame abandons it
    d0 = done_cnt;
    b0.start = 1'b1; b0.code = 8'h43;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", b0.tx, 1);
    chk("midrst_busy", b0.busy, 0);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    b0.start = 1'b1; b0.code = 8'h57;
    sbq.push_back('{8'h57, 1'b1});
    @(negedge clk);
    b0.start = 1'b0;
    wait_done("post_rst_done");

    // start held high: back-to-back frames with one done cycle between
    @(negedge clk);
    d0 = done_cnt;
    b0.start = 1'b1; b0.code = 8'h00;
    sbq.push_back('{8'h00, 1'b0});
    sbq.push_back('{8'h00, 1'b0});
    wait_done("b2b_first");
    @(negedge clk);
    chk("b2b_accept_busy", b0.busy, 1);
    chk("b2b_accept_tx", b0.tx, 0);
    b0.start = 1'b0;
    wait_done("b2b_second");
    @(negedge clk);
    dd = done_cnt - d0;
    chk("b2b_done_count", dd, 2);
    chk("sb_empty", sbq.size(), 0);

    // one-cycle bits, odd parity
    b1.start = 1'b1; b1.code = 8'h99;
    @(negedge clk);
    b1.start = 1'b0; b1.code = 8'h00;
    for (int k = 0; k < 11; k++) begin
      got[k] = b1.tx;
      gbusy[k] = b1.busy;
      if (k < 10) @(negedge clk);
    end
    @(negedge clk);
    chk("odd_frame", got, {1'b1, 1'b1, 8'h99, 1'b0});
    chk("odd_busy_len", gbusy, 11'h7FF);
    chk("odd_done", b1.done, 1);
    chk("odd_busy_end", b1.busy, 0);
    @(negedge clk);
    chk("odd_done_clear", b1.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bcd_code_tx.md
BCD_CODE_TX -- requirements
Module: bcd_code_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..255.
REQ-002 The block SHALL have parameter PARITY_EVEN, default 1: 1 = even parity, 0 = odd parity.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to send a frame; accepted on a rising clk edge with start=1 and busy=0.
REQ-006 The block SHALL have port code, input, 8 bits: two BCD digits, [7:4] tens digit and [3:0] ones digit; sampled only at acceptance.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line; idle level 1.
REQ-008 The block SHALL have port busy, output, 1 bit: frame in progress; start is ignored while busy=1.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected for an invalid BCD digit.
REQ-011 All outputs SHALL be registered; there SHALL be one clock domain; reset SHALL be synchronous and active-low.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a bit-period counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-013 Acceptance in IDLE with both nibbles <= 9 SHALL latch code into a shift register and move to START, with busy=1 and tx=0 from the next cycle.
REQ-014 Acceptance with either nibble > 9 SHALL pulse err for exactly one cycle, leave the FSM in IDLE, and keep tx=1 and busy=0.
REQ-015 Every bit SHALL hold tx constant for exactly CLKS_PER_BIT cycles.
REQ-016 The frame order SHALL be: start bit (0), 8 data bits LSB-first (code[0] first), parity bit, stop bit (1), giving 11*CLKS_PER_BIT cycles with busy=1.
REQ-017 The parity bit SHALL be the XOR of the 8 data bits when PARITY_EVEN=1, and its inverse when PARITY_EVEN=0.
REQ-018 STOP SHALL transition to IDLE after its last cycle; in the first IDLE cycle done=1, busy=0 and tx=1.
REQ-019 A start=1 seen at the edge ending the done cycle SHALL be accepted, so back-to-back frames have no idle gap beyond that one done cycle.
REQ-020 A start asserted while busy=1 SHALL be ignored: no queuing and no err.
REQ-021 Changes to code while busy=1 SHALL NOT affect the frame in progress.
REQ-022 done and err SHALL never be asserted in the same cycle, and neither SHALL be asserted for more than one consecutive cycle per event.
REQ-023 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle and the busy length SHALL be 11 cycles.

Reset
REQ-024 While reset_n=0 at a rising edge, the outputs SHALL be tx=1, busy=0, done=0, err=0, with state IDLE and the counters, bit index and shift register cleared.
REQ-025 A reset asserted mid-frame SHALL abandon the frame: tx=1 from the next cycle, and no done pulse for that frame.
REQ-026 The first request SHALL be accepted on the first edge with reset_n=1 and start=1.

Verification
REQ-027 CLKS_PER_BIT=4, PARITY_EVEN=1, code=8'h43, one-cycle start -> tx per 4-cycle bit: 0 | 1,1,0,0,0,0,1,0 | parity 1 | 1; busy high 44 cycles; then done=1 for one cycle.
REQ-028 code=8'h4A, start -> err=1 for one cycle; tx stays 1; busy stays 0; no done.
REQ-029 code=8'h99 with PARITY_EVEN=1 -> parity bit 0; the same code with PARITY_EVEN=0 -> parity bit 1.
REQ-030 Frame running with code=8'h43, start pulsed at cycle 10 of busy with code=8'h12 -> transmitted bits are still those of 8'h43; exactly one done.
REQ-031 reset_n=0 at cycle 20 of a frame -> tx=1, busy=0 next cycle; no done; a new start after release sends a complete frame.
REQ-032 start held at 1, code=8'h00 -> two consecutive frames separated only by the single done cycle; each frame has data bits all 0, parity 0, stop 1.
